// File: rtl/spi_slave.sv
// SPI mode-0 slave, 8-bit MSB-first full duplex, with TX holding register and RX valid/ready.
// Define SPI_SLAVE_OVERRUN_FLAG_EN to drop bytes arriving while RX is still unread and flag overrun_o.
//
// state     | meaning
// ST_IDLE   | slave select high; miso driven 0, waiting for a qualified ss falling edge
// ST_ACTIVE | frame in progress; shifting on synchronised spi_clk edges
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       spi_clk_i,
  input  logic       spi_ss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o,
  output logic       overrun_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, fill_q;
  logic                   sclk_prev_q, armed_q, armed_d;
  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [7:0]             hold_q, hold_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   hold_full_q, hold_full_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   miso_q, miso_d;
  logic                   done_q, done_d;

  logic       sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, move, tx_load;
  logic [7:0] next_tx;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign tx_load   = tx_valid_i & ~hold_full_q;
  assign next_tx   = hold_full_q ? hold_q : 8'h00;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    miso_d      = miso_q;
    done_d      = 1'b0;
    move        = 1'b0;
    // Only trust ss after the synchroniser holds real samples and has seen ss high,
    // so a frame already in progress at reset release is ignored.
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ss_s);

    case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = 3'd0;
        if (armed_q && !ss_s) begin
          state_d    = ST_ACTIVE;
          move       = 1'b1;
          tx_shift_d = next_tx;
          miso_d     = next_tx[7];
        end
      end
      ST_ACTIVE: begin
        if (ss_s) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
          miso_d    = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            done_d     = 1'b1;
            move       = 1'b1;
            tx_shift_d = next_tx;
            miso_d     = next_tx[7];
          end
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
          // The falling edge after bit 0 must not disturb the freshly loaded next byte.
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
          miso_d     = tx_shift_q[6];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_load) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end else if (move) begin
      hold_full_d = 1'b0;
    end

`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
    if (rx_valid_q && rx_ready_i) overrun_d = 1'b0;
`else
    overrun_d = 1'b0;
`endif

    if (done_q) begin
      if (rx_valid_q && !rx_ready_i) begin
`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
        overrun_d = 1'b1;
`else
        rx_data_d = rx_shift_q;
`endif
      end else begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
    end
  end

  assign spi_miso_o = miso_q;
  assign tx_ready_o = ~hold_full_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = (state_q == ST_ACTIVE);
  assign overrun_o  = overrun_q;

endmodule
